jk_excite_driver: RTL and testbench
===================================

JK_EXCITE_DRIVER -- requirements
Module: jk_excite_driver

Interface
REQ-001 Parameter USE_TOGGLE, default 0: when 1, a state change is requested with JK=11 (toggle) instead of 10 or 01.
REQ-002 Parameter CNT_W, default 8: width of err_cnt and xfer_cnt.
REQ-003 Port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 Port rst  input  1  reset; asynchronous, active-high.
REQ-005 Port tgt_valid  input  1  a target next-state bit is offered.
REQ-006 Port tgt_bit  input  1  target value the driven flip-flop shall hold after the transfer.
REQ-007 Port tgt_ready  output  1  the block accepts a target this cycle.
REQ-008 Port q_obs  input  1  q of the driven JK flip-flop, which is clocked by the same clk.
REQ-009 Port JK  output  2  JK[1]=J, JK[0]=K, registered, driven to the flip-flop.
REQ-010 Port jk_strobe  output  1  high in the cycle JK carries a live excitation.
REQ-011 Port err_clr  input  1  synchronous clear of err and err_cnt.
REQ-012 Port err  output  1  sticky mismatch flag.
REQ-013 Port err_cnt  output  CNT_W  mismatch count, saturating.
REQ-014 Port xfer_cnt  output  CNT_W  completed transfer count, wrapping.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, DRIVE, CHECK.
REQ-016 In IDLE, tgt_ready SHALL be 1; it SHALL be 0 in every other state.
REQ-017 A transfer SHALL occur on a rising edge where tgt_valid=1 and tgt_ready=1; the block latches tgt_bit and q_obs and moves to DRIVE.
REQ-018 JK SHALL be computed from the latched (q, target) pair per the excitation table:
  - 0->0: 00; 1->1: 00
  - 0->1: 10, or 11 if USE_TOGGLE=1
  - 1->0: 01, or 11 if USE_TOGGLE=1
REQ-019 In DRIVE, JK SHALL present the computed value and jk_strobe SHALL be 1 for exactly one cycle; the next state is CHECK unconditionally.
REQ-020 In IDLE and CHECK, JK SHALL be 00 (hold) and jk_strobe SHALL be 0.
REQ-021 In CHECK, q_obs SHALL be compared with the latched target. On mismatch, err is set to 1 and err_cnt increments, saturating at 2^CNT_W-1. xfer_cnt increments in every case, wrapping 2^CNT_W-1 -> 0. The next state is IDLE.
REQ-022 Latency SHALL be 3 cycles from acceptance to count update; peak throughput SHALL be one transfer per 3 cycles.
REQ-023 tgt_valid SHALL be ignored outside IDLE; no input buffering.
REQ-024 If err_clr=1 in the same cycle as a CHECK mismatch, the clear SHALL win: err=0 and err_cnt=0 after the edge.
REQ-025 err_clr SHALL NOT affect xfer_cnt or the FSM.
REQ-026 tgt_bit and q_obs SHALL be sampled only at acceptance (q_obs also in CHECK); changes at other times SHALL have no effect.

Reset
REQ-027 Asserting rst SHALL immediately force:
  - state IDLE
  - JK=00, jk_strobe=0, tgt_ready=1 (while in IDLE)
  - err=0, err_cnt=0, xfer_cnt=0
  - latched target and q cleared to 0
REQ-028 Reset asserted in DRIVE or CHECK SHALL abandon the transfer with no count update.
REQ-029 After rst deasserts, the first rising edge SHALL be able to accept a transfer.

Verification
REQ-030 USE_TOGGLE=0, FF at q=0, send targets 1,1,0,0 -> JK in DRIVE = 10,00,01,00; q follows 1,1,0,0; err=0; xfer_cnt=4.
REQ-031 USE_TOGGLE=1, same sequence -> JK in DRIVE = 11,00,11,00; err=0; xfer_cnt=4.
REQ-032 Force q_obs stuck at 0, send target 1 three times -> err=1, err_cnt=3 after the third CHECK; err_clr pulse -> err=0, err_cnt=0, xfer_cnt=3 unchanged.
REQ-033 CNT_W=2, stuck q_obs, 5 mismatching transfers -> err_cnt saturates at 3; xfer_cnt wraps to 1.
REQ-034 Assert rst during DRIVE -> JK=00 and jk_strobe=0 at once, xfer_cnt stays 0, tgt_ready=1 after release; hold tgt_valid=1 continuously -> acceptances exactly every 3 cycles.
REQ-035 Apply err_clr in the same cycle as a CHECK mismatch -> err=0, err_cnt=0, xfer_cnt incremented.

Source files
------------

// File: rtl/jk_excite_driver.sv
// Drives J/K excitation to an external JK flip-flop so that it reaches a requested
// target bit, then confirms the result and keeps mismatch and transfer counts.
//   state | meaning
//   IDLE  | ready for a target; JK holds 00
//   DRIVE | JK carries the excitation for the latched (q, target) pair
//   CHECK | flip-flop has updated; compare q_obs with target, bump counters
module jk_excite_driver #(
    parameter bit USE_TOGGLE = 1'b0,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tgt_valid,
    input  logic             tgt_bit,
    output logic             tgt_ready,
    input  logic             q_obs,
    output logic [1:0]       JK,
    output logic             jk_strobe,
    input  logic             err_clr,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] xfer_cnt
);

    typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t state_q, state_d;
    logic   lat_tgt, lat_q;
    logic   accept;
    logic   mismatch;
    logic [1:0] jk_exc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (tgt_valid) state_d = DRIVE;
            DRIVE:   state_d = CHECK;
            CHECK:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // JK is decoded only from the state and latched registers, so it stays stable
    // through the cycle the flip-flop samples it.
    always_comb begin
        tgt_ready = (state_q == IDLE);
        jk_strobe = (state_q == DRIVE);
        accept    = tgt_ready && tgt_valid;
        mismatch  = (state_q == CHECK) && (q_obs != lat_tgt);
        if (lat_q == lat_tgt) begin
            jk_exc = 2'b00;
        end else if (USE_TOGGLE) begin
            jk_exc = 2'b11;
        end else begin
            jk_exc = lat_tgt ? 2'b10 : 2'b01;
        end
        JK = jk_strobe ? jk_exc : 2'b00;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_tgt  <= 1'b0;
            lat_q    <= 1'b0;
            err      <= 1'b0;
            err_cnt  <= '0;
            xfer_cnt <= '0;
        end else begin
            if (accept) begin
                lat_tgt <= tgt_bit;
                lat_q   <= q_obs;
            end
            if (state_q == CHECK) begin
                xfer_cnt <= xfer_cnt + CNT_ONE;
            end
            // A clear coinciding with a mismatch wins.
            if (err_clr) begin
                err     <= 1'b0;
                err_cnt <= '0;
            end else if (mismatch) begin
                err <= 1'b1;
                if (err_cnt != CNT_MAX) begin
                    err_cnt <= err_cnt + CNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_jk_excite_driver.sv
// Bench for jk_excite_driver: two instances (plain 8-bit, toggle 2-bit) each driving a
// modelled JK flip-flop, checked against a transaction-level reference model.
module tb_jk_excite_driver;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic tgt_valid = 1'b0;
    logic tgt_bit   = 1'b0;
    logic err_clr   = 1'b0;
    logic stuck     = 1'b0;

    logic       rdy0, rdy1, str0, str1, err0, err1;
    logic [1:0] jk0, jk1;
    logic [7:0] ec0, xc0;
    logic [1:0] ec1, xc1;
    logic       qf0, qf1, q0, q1;

    assign q0 = stuck ? 1'b0 : qf0;
    assign q1 = stuck ? 1'b0 : qf1;

    jk_excite_driver #(.USE_TOGGLE(1'b0), .CNT_W(8)) u0 (
        .clk(clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_bit(tgt_bit),
        .tgt_ready(rdy0), .q_obs(q0), .JK(jk0), .jk_strobe(str0),
        .err_clr(err_clr), .err(err0), .err_cnt(ec0), .xfer_cnt(xc0));

    jk_excite_driver #(.USE_TOGGLE(1'b1), .CNT_W(2)) u1 (
        .clk(clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_bit(tgt_bit),
        .tgt_ready(rdy1), .q_obs(q1), .JK(jk1), .jk_strobe(str1),
        .err_clr(err_clr), .err(err1), .err_cnt(ec1), .xfer_cnt(xc1));

    // Driven JK flip-flops, clocked by the same clock.
    function automatic logic jk_next(logic [1:0] jk, logic q);
        case (jk)
            2'b01:   return 1'b0;
            2'b10:   return 1'b1;
            2'b11:   return ~q;
            default: return q;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            qf0 <= 1'b0;
            qf1 <= 1'b0;
        end else begin
            qf0 <= jk_next(jk0, qf0);
            qf1 <= jk_next(jk1, qf1);
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: per-instance error flag / counts, index 0 = u0, 1 = u1.
    int m_err[2];
    int m_ec[2];
    int m_xc[2];
    int m_max[2] = '{255, 3};

    function automatic logic [1:0] exc(logic q, logic t, bit tog);
        if (q == t) return 2'b00;
        if (tog) return 2'b11;
        return t ? 2'b10 : 2'b01;
    endfunction

    task automatic model_clear_all();
        for (int i = 0; i < 2; i++) begin
            m_err[i] = 0; m_ec[i] = 0; m_xc[i] = 0;
        end
    endtask

    task automatic model_xfer(input int i, input bit mm, input bit clr);
        if (clr) begin
            m_err[i] = 0; m_ec[i] = 0;
        end else if (mm) begin
            m_err[i] = 1;
            if (m_ec[i] < m_max[i]) m_ec[i]++;
        end
        m_xc[i] = (m_xc[i] + 1) % (m_max[i] + 1);
    endtask

    task automatic chk_counts();
        chk("err0", err0, m_err[0]);
        chk("err_cnt0", ec0, m_ec[0]);
        chk("xfer_cnt0", xc0, m_xc[0]);
        chk("err1", err1, m_err[1]);
        chk("err_cnt1", ec1, m_ec[1]);
        chk("xfer_cnt1", xc1, m_xc[1]);
    endtask

    task automatic do_xfer(input logic t, input bit clr);
        logic [1:0] e0, e1;
        bit mm0, mm1;
        @(negedge clk);
        chk("ready_idle0", rdy0, 1);
        chk("ready_idle1", rdy1, 1);
        e0 = exc(q0, t, 1'b0);
        e1 = exc(q1, t, 1'b1);
        tgt_valid = 1'b1;
        tgt_bit   = t;
        @(negedge clk);
        tgt_valid = 1'b0;
        tgt_bit   = 1'($urandom);
        chk("jk_drive0", jk0, e0);
        chk("jk_drive1", jk1, e1);
        chk("strobe_drive0", str0, 1);
        chk("strobe_drive1", str1, 1);
        chk("ready_drive0", rdy0, 0);
        @(negedge clk);
        tgt_bit = 1'($urandom);
        chk("jk_check0", jk0, 0);
        chk("jk_check1", jk1, 0);
        chk("strobe_check0", str0, 0);
        if (!stuck) begin
            chk("q_follow0", q0, t);
            chk("q_follow1", q1, t);
        end
        mm0 = (q0 != t);
        mm1 = (q1 != t);
        err_clr = clr;
        model_xfer(0, mm0, clr);
        model_xfer(1, mm1, clr);
        @(negedge clk);
        err_clr = 1'b0;
        chk_counts();
    endtask

    task automatic clr_idle();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_err[i] = 0; m_ec[i] = 0;
        end
        chk_counts();
    endtask

    initial begin
        int acc;
        int last;
        model_clear_all();
        #2;
        chk("rst_ready0", rdy0, 1);
        chk("rst_jk0", jk0, 0);
        chk("rst_strobe0", str0, 0);
        chk_counts();
        @(negedge clk);
        rst = 1'b0;

        // Targets 1,1,0,0 from q=0, both excitation styles.
        do_xfer(1'b1, 1'b0);
        do_xfer(1'b1, 1'b0);
        do_xfer(1'b0, 1'b0);
        do_xfer(1'b0, 1'b0);
        chk("xfer_four0", xc0, 4);

        // Stuck-at-0 observation: three mismatches, then a clear.
        stuck = 1'b1;
        repeat (3) do_xfer(1'b1, 1'b0);
        chk("err_cnt_three0", ec0, 3);
        clr_idle();

        // Saturation on the 2-bit instance, wrap of its transfer count.
        repeat (5) do_xfer(1'b1, 1'b0);

        // Clear coinciding with a mismatch.
        do_xfer(1'b1, 1'b1);
        stuck = 1'b0;

        // Continuous tgt_valid: one acceptance every third edge.
        @(negedge clk);
        tgt_valid = 1'b1;
        tgt_bit   = 1'($urandom);
        acc = 0;
        last = -3;
        for (int c = 0; c < 12; c++) begin
            if (rdy0) begin
                chk("accept_gap", c - last, 3);
                last = c;
                acc++;
            end
            @(negedge clk);
        end
        tgt_valid = 1'b0;
        chk("accept_count", acc, 4);
        repeat (4) begin
            model_xfer(0, 1'b0, 1'b0);
            model_xfer(1, 1'b0, 1'b0);
        end
        chk_counts();

        // Reset in the middle of DRIVE.
        @(negedge clk);
        tgt_valid = 1'b1;
        tgt_bit   = ~q0;
        @(negedge clk);
        tgt_valid = 1'b0;
        chk("pre_rst_strobe", str0, 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_drive_jk0", jk0, 0);
        chk("rst_drive_jk1", jk1, 0);
        chk("rst_drive_strobe0", str0, 0);
        chk("rst_drive_ready0", rdy0, 1);
        model_clear_all();
        chk_counts();
        @(negedge clk);
        rst = 1'b0;
        tgt_valid = 1'b1;
        tgt_bit   = 1'b1;
        @(negedge clk);
        tgt_valid = 1'b0;
        chk("first_edge_accept", str0, 1);
        chk("first_edge_jk0", jk0, 2'b10);
        @(negedge clk);
        @(negedge clk);
        model_xfer(0, 1'b0, 1'b0);
        model_xfer(1, 1'b0, 1'b0);
        chk_counts();

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            stuck = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) == 0) clr_idle();
            do_xfer(1'($urandom), ($urandom_range(0, 5) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
